// File: rtl/key_pulse_gen.sv
// Four-button front end: synchronise, debounce, arbitrate presses by priority U>D>R>L
// and generate single-cycle direction strobes with hold-to-repeat.
module key_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] btn_raw,
    input  logic       en,
    output logic       U,
    output logic       D,
    output logic       R,
    output logic       L,
    output logic       key_valid,
    output logic [1:0] key_code
);

    // All three periods must be >= 2 so every terminal count below is a real count.
    localparam logic [27:0] DEB_LAST   = 28'(DEBOUNCE_CYC - 1);
    localparam logic [27:0] DELAY_LAST = 28'(REPEAT_DELAY - 1);
    localparam logic [27:0] RATE_LAST  = 28'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [3:0]  sync_q1;
    logic [3:0]  sync_q2;
    logic [3:0]  deb_lvl;
    logic [3:0]  deb_prev;
    logic [27:0] deb_cnt [4];

    logic [3:0]  press;
    logic        press_any;
    logic [1:0]  press_code;

    state_t      state;
    state_t      state_nx;
    logic [27:0] rpt_cnt;
    logic [27:0] rpt_cnt_nx;
    logic [1:0]  held;
    logic [1:0]  held_nx;
    logic        held_live;
    logic        cnt_hit;
    logic        fire;
    logic [1:0]  fire_code;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // A level is accepted only after it differs from the debounced level for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            deb_lvl  <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            deb_prev <= deb_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync_q2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 28'd1;
                end
            end
        end
    end

    assign press     = deb_lvl & ~deb_prev;
    assign press_any = |press;
    assign held_live = deb_lvl[held];
    assign cnt_hit   = ((state == DELAY)  && (rpt_cnt == DELAY_LAST)) ||
                       ((state == REPEAT) && (rpt_cnt == RATE_LAST));

    // NOTE: each always_comb assigns defaults first so no path can infer a latch.
    always_comb begin
        press_code = 2'd0;
        if (press[3])      press_code = 2'd3;
        else if (press[2]) press_code = 2'd2;
        else if (press[1]) press_code = 2'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            held    <= '0;
        end else begin
            state   <= state_nx;
            rpt_cnt <= rpt_cnt_nx;
            held    <= held_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rpt_cnt_nx = rpt_cnt;
        held_nx    = held;
        if (!en) begin
            state_nx   = IDLE;
            rpt_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_any) begin
                        state_nx   = DELAY;
                        rpt_cnt_nx = '0;
                        held_nx    = press_code;
                    end
                end
                DELAY, REPEAT: begin
                    // A fresh press outranks both the release check and a due repeat.
                    if (press_any) begin
                        state_nx   = DELAY;
                        rpt_cnt_nx = '0;
                        held_nx    = press_code;
                    end else if (!held_live) begin
                        state_nx   = IDLE;
                        rpt_cnt_nx = '0;
                    end else if (cnt_hit) begin
                        state_nx   = REPEAT;
                        rpt_cnt_nx = '0;
                    end else begin
                        rpt_cnt_nx = rpt_cnt + 28'd1;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    rpt_cnt_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        fire      = 1'b0;
        fire_code = held;
        if (en) begin
            if (press_any) begin
                fire      = 1'b1;
                fire_code = press_code;
            end else if (held_live && cnt_hit) begin
                fire      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            U         <= 1'b0;
            D         <= 1'b0;
            R         <= 1'b0;
            L         <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 2'd0;
        end else begin
            U         <= fire && (fire_code == 2'd3);
            D         <= fire && (fire_code == 2'd2);
            R         <= fire && (fire_code == 2'd1);
            L         <= fire && (fire_code == 2'd0);
            key_valid <= fire;
            key_code  <= fire ? fire_code : 2'd0;
        end
    end

endmodule
